// File: rtl/ram_bw_sp_if.sv
// Request/response bus for the byte-write single-port RAM.
// The master issues requests and the slave returns one response per accepted request.
interface ram_bw_sp_if #(
    parameter int WSIZE = 4,
    parameter int AW    = 7
);
    logic                 req_valid;
    logic                 req_ready;
    logic [WSIZE-1:0]     req_we;
    logic [AW-1:0]        req_addr;
    logic [WSIZE*8-1:0]   req_wdata;
    logic                 rsp_valid;
    logic [WSIZE*8-1:0]   rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ram_bw_sp.sv
// Single-port word RAM with per-byte write enables.
// A partial write is a read-modify-write over two cycles.
module ram_bw_sp #(
    parameter int DEPTH = 128,
    parameter int WSIZE = 4,
    parameter int AW    = 7
) (
    input  logic          CLK,
    input  logic          RST,
    ram_bw_sp_if.slave    bus
);
    localparam int DW = WSIZE * 8;

    typedef enum logic {IDLE, MERGE} state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   mem [0:DEPTH-1];

    logic [AW-1:0]   addr_q;
    logic [WSIZE-1:0] mask_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   old_q;
    logic [DW-1:0]   merged;

    logic            acc, inr, is_rd, is_full, is_part;
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [DW-1:0]   mem_wd;

    assign inr     = (int'(bus.req_addr) < DEPTH);
    assign is_rd   = (bus.req_we == '0);
    assign is_full = (&bus.req_we);
    assign is_part = !is_rd && !is_full;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (acc && is_part && inr) state_nx = MERGE;
            MERGE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = !RST && (state == IDLE);
        acc           = bus.req_valid && bus.req_ready;
        for (int i = 0; i < WSIZE; i++) begin
            merged[8*i +: 8] = mask_q[i] ? wdata_q[8*i +: 8] : old_q[8*i +: 8];
        end
        mem_we = 1'b0;
        mem_wa = bus.req_addr;
        mem_wd = bus.req_wdata;
        // A reset landing in MERGE drops the pending write
        if (state == MERGE && !RST) begin
            mem_we = 1'b1;
            mem_wa = addr_q;
            mem_wd = merged;
        end else if (acc && is_full && inr) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge CLK) begin
        if (acc && is_part && inr) begin
            addr_q  <= bus.req_addr;
            mask_q  <= bus.req_we;
            wdata_q <= bus.req_wdata;
            old_q   <= mem[bus.req_addr];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            if (state == MERGE) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_rdata <= merged;
            end else if (acc) begin
                if (!inr) begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b1;
                    bus.rsp_rdata <= '0;
                end else if (is_rd) begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= mem[bus.req_addr];
                end else if (is_full) begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= bus.req_wdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_bw_sp.sv
// Bench for ram_bw_sp: directed vectors plus a word-level memory model
// checked against the DUT on every cycle.
module tb_ram_bw_sp;
    localparam int DEPTH = 100;
    localparam int WS    = 4;
    localparam int AW    = 7;
    localparam int DW    = WS * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_bw_sp_if #(.WSIZE(WS), .AW(AW)) bus ();

    ram_bw_sp #(.DEPTH(DEPTH), .WSIZE(WS), .AW(AW)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: word array, expected response for the current cycle
    logic [DW-1:0] mem_m [0:DEPTH-1];
    logic          exp_v = 1'b0;
    logic [DW-1:0] exp_d = '0;
    logic          exp_e = 1'b0;
    logic          pend  = 1'b0;
    logic [AW-1:0] pa;
    logic [DW-1:0] pm;
    logic          started = 1'b0;
    int            pulses = 0;

    always @(posedge clk) begin
        logic [DW-1:0] w;
        started = 1'b1;
        if (rst) begin
            exp_v = 1'b0; exp_d = '0; exp_e = 1'b0; pend = 1'b0;
        end else begin
            exp_v = 1'b0; exp_e = 1'b0;
            if (pend) begin
                mem_m[pa] = pm;
                exp_v = 1'b1; exp_d = pm; pend = 1'b0;
            end else if (bus.req_valid) begin
                if (int'(bus.req_addr) >= DEPTH) begin
                    exp_v = 1'b1; exp_d = '0; exp_e = 1'b1;
                end else if (bus.req_we == '0) begin
                    exp_v = 1'b1; exp_d = mem_m[bus.req_addr];
                end else begin
                    w = mem_m[bus.req_addr];
                    for (int b = 0; b < WS; b++)
                        if (bus.req_we[b]) w[8*b +: 8] = bus.req_wdata[8*b +: 8];
                    if (&bus.req_we) begin
                        mem_m[bus.req_addr] = w;
                        exp_v = 1'b1; exp_d = w;
                    end else begin
                        pend = 1'b1; pa = bus.req_addr; pm = w;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ready", 64'(bus.req_ready), 64'(!rst && !pend));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
            chk("rsp_err", 64'(bus.rsp_err), 64'(exp_e));
            chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_d));
            if (bus.rsp_valid) pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [WS-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        tick();
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        tick();
    endtask

    initial begin
        int p0;
        bus.req_valid = 1'b0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("reset err", 64'(bus.rsp_err), 64'd0);

        for (int i = 0; i < DEPTH; i++) put('1, AW'(i), 32'hC0DE0000 | 32'(i));
        idle();

        // full write then read
        put('1, 7'd5, 32'hDEADBEEF);
        chk("t1 wr rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        put('0, 7'd5, '0);
        chk("t1 rd rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        chk("t1 rd err", 64'(bus.rsp_err), 64'd0);

        // partial write: one cycle with ready low
        put(4'b0101, 7'd5, 32'h11223344);
        chk("t2 merge ready", 64'(bus.req_ready), 64'd0);
        chk("t2 merge novalid", 64'(bus.rsp_valid), 64'd0);
        idle();
        chk("t2 rsp valid", 64'(bus.rsp_valid), 64'd1);
        chk("t2 rsp rdata", 64'(bus.rsp_rdata), 64'hDE22BE44);
        chk("t2 model", 64'(exp_d), 64'hDE22BE44);
        put('0, 7'd5, '0);
        chk("t2 rd rdata", 64'(bus.rsp_rdata), 64'hDE22BE44);
        idle();

        // out of range
        put('1, 7'd100, 32'h55555555);
        chk("t4 wr err", 64'(bus.rsp_err), 64'd1);
        put(4'b0010, 7'd101, 32'h12345678);
        chk("t4 part err", 64'(bus.rsp_err), 64'd1);
        chk("t4 part ready", 64'(bus.req_ready), 64'd1);
        put('0, 7'd100, '0);
        chk("t4 rd err", 64'(bus.rsp_err), 64'd1);
        chk("t4 rd rdata", 64'(bus.rsp_rdata), 64'd0);
        put('0, 7'd99, '0);
        chk("t4 rd 99", 64'(bus.rsp_rdata), 64'hC0DE0063);
        chk("t4 rd 99 err", 64'(bus.rsp_err), 64'd0);
        idle();

        // back-to-back reads over the whole address range
        p0 = pulses;
        for (int i = 0; i < 128; i++) put('0, AW'(i), '0);
        idle();
        chk("t3 pulses", 64'(pulses - p0), 64'd128);

        // reset during MERGE drops the write
        put('1, 7'd7, 32'hA5A5A5A5);
        put(4'b0011, 7'd7, 32'h0);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("t5 no rsp", 64'(bus.rsp_valid), 64'd0);
        idle();
        chk("t5 still no rsp", 64'(bus.rsp_valid), 64'd0);
        put('0, 7'd7, '0);
        chk("t5 rd", 64'(bus.rsp_rdata), 64'hA5A5A5A5);

        // random mix
        for (int n = 0; n < 400; n++) begin
            int k;
            logic [WS-1:0] m;
            k = int'($urandom_range(0, 3));
            m = (k == 0) ? '0 : (k == 1) ? '1 : WS'($urandom);
            put(m, AW'($urandom_range(0, DEPTH + 9)), DW'($urandom));
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle(); idle();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
